// File: rtl/upg_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// upg_mode_ctrl_if
// Bundle of the signals exchanged between the UART program-upload sequencer
// and its surroundings (button, UART programmer IP, programrom / dmemory32
// upload write ports, CPU reset tree).
//
// Signals
//   start_pg      raw start button (asynchronous to clk)
//   upg_wen_i     programmer write strobe
//   upg_adr_i     programmer word address, bit 14 selects dmem
//   upg_done_i    programmer finished (level)
//   upg_rst_o     reset to the UART programmer IP, active-high
//   cpu_rst_o     CPU reset hold, active-high
//   rom_wen_o     programrom upload write enable
//   dmem_wen_o    dmemory32 upload write enable
//   upg_adr_o     upg_adr_i[13:0] passed through to the memories
//   rom_words_o   ROM words written in the current / last upload
//   dmem_words_o  dmem words written in the current / last upload
//   busy_o        upload in progress (ARM or LOAD)
//   err_o         sticky upload-timeout flag
//
// Modports
//   slave   the sequencer itself
//   master  whatever drives the sequencer (top level or a testbench)
// -----------------------------------------------------------------------------
interface upg_mode_ctrl_if;
   logic        start_pg;
   logic        upg_wen_i;
   logic [14:0] upg_adr_i;
   logic        upg_done_i;
   logic        upg_rst_o;
   logic        cpu_rst_o;
   logic        rom_wen_o;
   logic        dmem_wen_o;
   logic [13:0] upg_adr_o;
   logic [14:0] rom_words_o;
   logic [14:0] dmem_words_o;
   logic        busy_o;
   logic        err_o;

   modport slave (
      input  start_pg,
      input  upg_wen_i,
      input  upg_adr_i,
      input  upg_done_i,
      output upg_rst_o,
      output cpu_rst_o,
      output rom_wen_o,
      output dmem_wen_o,
      output upg_adr_o,
      output rom_words_o,
      output dmem_words_o,
      output busy_o,
      output err_o
   );

   modport master (
      output start_pg,
      output upg_wen_i,
      output upg_adr_i,
      output upg_done_i,
      input  upg_rst_o,
      input  cpu_rst_o,
      input  rom_wen_o,
      input  dmem_wen_o,
      input  upg_adr_o,
      input  rom_words_o,
      input  dmem_words_o,
      input  busy_o,
      input  err_o
   );
endinterface

// File: rtl/upg_mode_ctrl.sv
// -----------------------------------------------------------------------------
// upg_mode_ctrl
// Sequencer for UART program-upload mode. Debounces the start button, holds
// the CPU in reset while an upload is in progress, enables the UART
// programmer IP, steers every programmer write to the instruction ROM or the
// data memory, counts the words written to each and aborts a stalled upload.
//
// Ports
//   clk     single clock (programmer clock domain)
//   rst_n   asynchronous active-low reset
//   bus     upg_mode_ctrl_if.slave, see the interface file for the signals
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive synced-high cycles before a press is accepted
//   RELEASE_CYCLES   cycles the CPU stays in reset after boot / after upload
//   TIMEOUT_CYCLES   maximum idle cycles between writes while loading
//
// State flow
//   BOOT -> RUN -> ARM -> LOAD -> DRAIN -> RUN
//                   \------------^  (done with no writes)
// -----------------------------------------------------------------------------
module upg_mode_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int RELEASE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES  = 2000000
) (
   input  logic           clk,
   input  logic           rst_n,
   upg_mode_ctrl_if.slave bus
);

   localparam int DEB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int REL_W  = (RELEASE_CYCLES  > 2) ? $clog2(RELEASE_CYCLES)  : 1;
   localparam int IDLE_W = (TIMEOUT_CYCLES  > 2) ? $clog2(TIMEOUT_CYCLES)  : 1;

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RELEASE_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [14:0]       WORDS_MAX = 15'h7FFF;

   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_RUN   = 3'd1,
      S_ARM   = 3'd2,
      S_LOAD  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              upg_rst_q, upg_rst_d;

   logic [1:0]        sync_q;
   logic              btn_s;

   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic              rearm_blk_q, rearm_blk_d;
   logic              err_q, err_d;

   logic              deb_done;
   logic              rel_done;
   logic              timeout_hit;
   logic              arm_entry;
   logic              wr_window;
   logic              rom_wen;
   logic              dmem_wen;
   logic [1:0]        wen_vec;

   // ------------------------------------------------------------------------
   // Button synchroniser (two flops, the raw button is asynchronous)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], bus.start_pg};
      end
   end

   assign btn_s = sync_q[1];

   // ------------------------------------------------------------------------
   // Event decode shared by the FSM and the counters
   // ------------------------------------------------------------------------
   // A press is accepted only when the re-arm latch is clear, so a button
   // still held from the previous upload cannot start another one.
   assign deb_done    = (state_q == S_RUN) && btn_s && !rearm_blk_q &&
                        (deb_cnt_q == DEB_LAST);
   assign rel_done    = (rel_cnt_q == REL_LAST);
   // A write in the same cycle restarts the idle window; done wins anyway.
   assign timeout_hit = (state_q == S_LOAD) && !bus.upg_wen_i &&
                        !bus.upg_done_i && (idle_cnt_q == IDLE_LAST);
   assign arm_entry   = deb_done;

   // ------------------------------------------------------------------------
   // FSM: state register (outputs registered alongside the state)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_BOOT;
         busy_q    <= 1'b0;
         cpu_rst_q <= 1'b1;
         upg_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         cpu_rst_q <= cpu_rst_d;
         upg_rst_q <= upg_rst_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_BOOT: begin
            if (rel_done) state_d = S_RUN;
         end
         S_RUN: begin
            if (deb_done) state_d = S_ARM;
         end
         S_ARM: begin
            // The first write is steered and counted in ARM itself; if done
            // coincides with it the upload is already over.
            if (bus.upg_done_i)     state_d = S_DRAIN;
            else if (bus.upg_wen_i) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (bus.upg_done_i || timeout_hit) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (rel_done) state_d = S_RUN;
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output logic, decoded from the next state so the registered
   // outputs change on the same edge as the state.
   // ------------------------------------------------------------------------
   always_comb begin
      busy_d    = 1'b0;
      cpu_rst_d = 1'b1;
      upg_rst_d = 1'b1;
      unique case (state_d)
         S_RUN: begin
            cpu_rst_d = 1'b0;
         end
         S_ARM, S_LOAD: begin
            busy_d    = 1'b1;
            upg_rst_d = 1'b0;
         end
         default: begin
            busy_d    = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Debounce, release, idle counters, re-arm latch and error flag
   // ------------------------------------------------------------------------
   always_comb begin
      // Debounce: counts synced-high cycles in RUN, any low cycle restarts it.
      deb_cnt_d = '0;
      if ((state_q == S_RUN) && btn_s && !rearm_blk_q && !deb_done) begin
         deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end

      // Release: the same counter times both BOOT and DRAIN.
      rel_cnt_d = '0;
      if (((state_q == S_BOOT) || (state_q == S_DRAIN)) && !rel_done) begin
         rel_cnt_d = rel_cnt_q + REL_W'(1);
      end

      // Idle: only LOAD is supervised; ARM may wait indefinitely.
      idle_cnt_d = '0;
      if ((state_q == S_LOAD) && !bus.upg_wen_i && !timeout_hit) begin
         idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end

      rearm_blk_d = rearm_blk_q;
      if (!btn_s) begin
         rearm_blk_d = 1'b0;
      end else if (deb_done) begin
         rearm_blk_d = 1'b1;
      end

      err_d = err_q;
      if (arm_entry) begin
         err_d = 1'b0;
      end else if (timeout_hit) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt_q   <= '0;
         rel_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         rearm_blk_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         deb_cnt_q   <= deb_cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         rearm_blk_q <= rearm_blk_d;
         err_q       <= err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Write steering: only ARM and LOAD may reach the memories. Because it is
   // decoded from state_q, an asynchronous reset kills both enables at once.
   // ------------------------------------------------------------------------
   assign wr_window = (state_q == S_ARM) || (state_q == S_LOAD);
   assign rom_wen   = wr_window && bus.upg_wen_i && !bus.upg_adr_i[14];
   assign dmem_wen  = wr_window && bus.upg_wen_i &&  bus.upg_adr_i[14];
   assign wen_vec   = {dmem_wen, rom_wen};

   // ------------------------------------------------------------------------
   // Word counters: index 0 = ROM, index 1 = dmem. Cleared on ARM entry,
   // saturating, and holding their value after the upload for inspection.
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_words
      logic [14:0] words_q, words_d;

      always_comb begin
         words_d = words_q;
         if (arm_entry) begin
            words_d = '0;
         end else if (wen_vec[gi] && (words_q != WORDS_MAX)) begin
            words_d = words_q + 15'd1;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            words_q <= '0;
         end else begin
            words_q <= words_d;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.upg_rst_o    = upg_rst_q;
   assign bus.cpu_rst_o    = cpu_rst_q;
   assign bus.busy_o       = busy_q;
   assign bus.err_o        = err_q;
   assign bus.rom_wen_o    = rom_wen;
   assign bus.dmem_wen_o   = dmem_wen;
   assign bus.upg_adr_o    = bus.upg_adr_i[13:0];
   assign bus.rom_words_o  = g_words[0].words_q;
   assign bus.dmem_words_o = g_words[1].words_q;

endmodule

// File: tb/tb_upg_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_upg_mode_ctrl
// Directed bench for upg_mode_ctrl with a short timeout. Upload traffic is
// a table of {inputs, expected outputs}; boot, debounce, timeout, re-arm and
// asynchronous-reset behaviour are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_upg_mode_ctrl;

   localparam int DEB  = 1000;
   localparam int REL  = 8;
   localparam int TOUT = 50;
   // start_pg driven just after edge P0 reaches ARM on edge P0+DEB+2
   // (two synchroniser stages, then DEB counted cycles).
   localparam int ARM_LAT = DEB + 2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   upg_mode_ctrl_if bus ();

   upg_mode_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .RELEASE_CYCLES  (REL),
      .TIMEOUT_CYCLES  (TOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic        wen;
      logic [14:0] adr;
      logic        done;
      logic        e_rom;
      logic        e_dmem;
      logic [14:0] e_rw;
      logic [14:0] e_dw;
      logic        e_busy;
   } vec_t;

   vec_t vecs [10];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply one table entry: enables are checked combinationally before the
   // edge, counters and busy after it.
   task automatic apply(input int i);
      bus.upg_wen_i  = vecs[i].wen;
      bus.upg_adr_i  = vecs[i].adr;
      bus.upg_done_i = vecs[i].done;
      #1;
      check($sformatf("v%0d_rom_wen", i), 32'(bus.rom_wen_o), 32'(vecs[i].e_rom));
      check($sformatf("v%0d_dmem_wen", i), 32'(bus.dmem_wen_o), 32'(vecs[i].e_dmem));
      tick();
      check($sformatf("v%0d_rom_words", i), 32'(bus.rom_words_o), 32'(vecs[i].e_rw));
      check($sformatf("v%0d_dmem_words", i), 32'(bus.dmem_words_o), 32'(vecs[i].e_dw));
      check($sformatf("v%0d_busy", i), 32'(bus.busy_o), 32'(vecs[i].e_busy));
      $display("vec %0d wen=%0b adr=%h done=%0b -> rom_words=%0d dmem_words=%0d busy=%0b",
               i, vecs[i].wen, vecs[i].adr, vecs[i].done,
               bus.rom_words_o, bus.dmem_words_o, bus.busy_o);
      bus.upg_wen_i  = 1'b0;
      bus.upg_done_i = 1'b0;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) apply(i);
   endtask

   // Release reset just after an edge and measure how long cpu_rst_o holds.
   task automatic boot_check(input string tag);
      int n;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < 3 * REL; k++) begin
         @(negedge clk);
         if (bus.cpu_rst_o) n++;
         else break;
      end
      check({tag, "_cpu_rst_len"}, 32'(n), 32'(REL));
      check({tag, "_upg_rst"}, 32'(bus.upg_rst_o), 32'd1);
      check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
      $display("%s: cpu_rst_o high for %0d cycles", tag, n);
   endtask

   // Hold the button until ARM is reached; measures acceptance latency.
   task automatic press(input string tag);
      int n;
      tick();
      bus.start_pg = 1'b1;
      n = 0;
      while (!bus.busy_o && n < ARM_LAT + 100) begin
         tick();
         n++;
      end
      check({tag, "_arm_latency"}, 32'(n), 32'(ARM_LAT));
      check({tag, "_arm_cpu_rst"}, 32'(bus.cpu_rst_o), 32'd1);
      check({tag, "_arm_upg_rst"}, 32'(bus.upg_rst_o), 32'd0);
      check({tag, "_arm_err"}, 32'(bus.err_o), 32'd0);
      $display("%s: armed after %0d cycles", tag, n);
   endtask

   // From DRAIN entry, count cycles until the CPU is released.
   task automatic drain_check(input string tag);
      int n;
      n = 0;
      while (bus.cpu_rst_o && n < 3 * REL) begin
         tick();
         n++;
      end
      check({tag, "_drain_len"}, 32'(n), 32'(REL));
      check({tag, "_run_upg_rst"}, 32'(bus.upg_rst_o), 32'd1);
      $display("%s: drain lasted %0d cycles", tag, n);
   endtask

   initial begin
      int n;
      //            wen   adr       done  rom   dmem  rw     dw     busy
      vecs[0] = '{1'b1, 15'h0000, 1'b0, 1'b1, 1'b0, 15'd1, 15'd0, 1'b1};
      vecs[1] = '{1'b1, 15'h0001, 1'b0, 1'b1, 1'b0, 15'd2, 15'd0, 1'b1};
      vecs[2] = '{1'b1, 15'h0002, 1'b0, 1'b1, 1'b0, 15'd3, 15'd0, 1'b1};
      vecs[3] = '{1'b0, 15'h4000, 1'b0, 1'b0, 1'b0, 15'd3, 15'd0, 1'b1};
      vecs[4] = '{1'b1, 15'h4000, 1'b0, 1'b0, 1'b1, 15'd3, 15'd1, 1'b1};
      vecs[5] = '{1'b1, 15'h4001, 1'b0, 1'b0, 1'b1, 15'd3, 15'd2, 1'b1};
      vecs[6] = '{1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 15'd3, 15'd2, 1'b0};
      // second upload: write and done in the same cycle
      vecs[7] = '{1'b1, 15'h0010, 1'b0, 1'b1, 1'b0, 15'd1, 15'd0, 1'b1};
      vecs[8] = '{1'b1, 15'h4005, 1'b1, 1'b0, 1'b1, 15'd1, 15'd1, 1'b0};
      // timeout upload: single write
      vecs[9] = '{1'b1, 15'h0003, 1'b0, 1'b1, 1'b0, 15'd1, 15'd0, 1'b1};

      bus.start_pg   = 1'b0;
      bus.upg_wen_i  = 1'b0;
      bus.upg_adr_i  = 15'h5ABC;
      bus.upg_done_i = 1'b0;
      rst_n          = 1'b0;

      // ---- reset state and boot ----
      repeat (3) @(posedge clk);
      #1;
      check("rst_upg_rst", 32'(bus.upg_rst_o), 32'd1);
      check("rst_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
      check("rst_rom_words", 32'(bus.rom_words_o), 32'd0);
      check("rst_dmem_words", 32'(bus.dmem_words_o), 32'd0);
      check("rst_err", 32'(bus.err_o), 32'd0);
      check("adr_passthru", 32'(bus.upg_adr_o), 32'h1ABC);
      boot_check("boot");

      // ---- glitch: 999 cycles high is not a press ----
      tick();
      bus.start_pg = 1'b1;
      repeat (DEB - 1) tick();
      bus.start_pg = 1'b0;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.busy_o || bus.cpu_rst_o) n++;
      end
      check("glitch_no_arm", 32'(n), 32'd0);
      $display("glitch: %0d cycles busy/cpu_rst after 999-cycle press", n);

      // ---- valid press and main upload ----
      press("up1");
      bus.start_pg = 1'b0;
      check("up1_words_clr", 32'(bus.rom_words_o), 32'd0);
      run_vecs(0, 6);
      // DRAIN must block writes even if the programmer still strobes
      bus.upg_wen_i = 1'b1;
      bus.upg_adr_i = 15'h0000;
      #1;
      check("drain_rom_wen_forced", 32'(bus.rom_wen_o), 32'd0);
      drain_check("up1");
      bus.upg_wen_i = 1'b0;
      check("up1_rw_hold", 32'(bus.rom_words_o), 32'd3);
      check("up1_dw_hold", 32'(bus.dmem_words_o), 32'd2);

      // ---- write and done in the same cycle ----
      press("up2");
      bus.start_pg = 1'b0;
      check("up2_rw_clr", 32'(bus.rom_words_o), 32'd0);
      check("up2_dw_clr", 32'(bus.dmem_words_o), 32'd0);
      run_vecs(7, 8);
      check("up2_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
      drain_check("up2");

      // ---- timeout ----
      press("up3");
      bus.start_pg = 1'b0;
      run_vecs(9, 9);
      n = 0;
      while (!bus.err_o && n < 4 * TOUT) begin
         tick();
         n++;
      end
      check("timeout_len", 32'(n), 32'(TOUT));
      check("timeout_busy", 32'(bus.busy_o), 32'd0);
      check("timeout_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
      check("timeout_upg_rst", 32'(bus.upg_rst_o), 32'd1);
      $display("timeout: err_o after %0d idle cycles", n);
      drain_check("up3");
      check("err_sticky", 32'(bus.err_o), 32'd1);

      // ---- next press clears err; button kept held ----
      press("up4");
      check("up4_rw_clr", 32'(bus.rom_words_o), 32'd0);
      // done with no writes: ARM goes straight to DRAIN
      bus.upg_done_i = 1'b1;
      tick();
      bus.upg_done_i = 1'b0;
      check("arm_done_busy", 32'(bus.busy_o), 32'd0);
      check("arm_done_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
      drain_check("up4");
      // still held: must not re-arm
      n = 0;
      for (int k = 0; k < DEB + 100; k++) begin
         tick();
         if (bus.busy_o) n++;
      end
      check("held_no_rearm", 32'(n), 32'd0);
      $display("held button: %0d busy cycles while held after drain", n);
      // release for one cycle, then press again
      bus.start_pg = 1'b0;
      press("up5");
      bus.start_pg = 1'b0;

      // ---- async reset mid-LOAD ----
      bus.upg_wen_i = 1'b1;
      bus.upg_adr_i = 15'h4002;
      tick();
      check("pre_rst_dw", 32'(bus.dmem_words_o), 32'd1);
      check("pre_rst_busy", 32'(bus.busy_o), 32'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_dmem_wen", 32'(bus.dmem_wen_o), 32'd0);
      check("arst_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
      check("arst_upg_rst", 32'(bus.upg_rst_o), 32'd1);
      check("arst_busy", 32'(bus.busy_o), 32'd0);
      check("arst_dmem_words", 32'(bus.dmem_words_o), 32'd0);
      $display("async reset: outputs cpu_rst=%0b upg_rst=%0b dmem_wen=%0b",
               bus.cpu_rst_o, bus.upg_rst_o, bus.dmem_wen_o);
      bus.upg_wen_i = 1'b0;
      repeat (3) @(posedge clk);
      boot_check("reboot");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/upg_mode_ctrl.md
Name: upg_mode_ctrl

Overview:
- Sequencer for UART program-upload mode: debounces the start_pg button, holds the CPU in reset during upload, and enables the UART programmer IP.
- Steers each programmer write to the instruction ROM or the data memory, counts the words written, and detects a stalled upload.
- Sits between the UART programmer IP, programrom/dmemory32 write ports and the CPU reset tree. Replaces the ad-hoc upg_rst logic at top level.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive cycles start_pg must read 1 before it is accepted.
- RELEASE_CYCLES, 8: cycles cpu_rst_o stays high after boot or after upload done.
- TIMEOUT_CYCLES, 2000000: maximum cycles between writes in LOAD before the upload is aborted.

Ports:
- clock  in  1  single clock (upg_clk_o domain).
- rst  in  1  asynchronous, active-low reset.
- start_pg  in  1  raw button, synchronised internally with 2 flops.
- upg_wen_i  in  1  programmer write strobe.
- upg_adr_i  in  15  programmer word address; bit 14 = 1 selects dmem.
- upg_done_i  in  1  programmer finished, level signal.
- upg_rst_o  out  1  reset to UART programmer IP, active-high.
- cpu_rst_o  out  1  CPU reset hold, active-high.
- rom_wen_o  out  1  programrom upload write enable.
- dmem_wen_o  out  1  dmemory32 upload write enable.
- upg_adr_o  out  14  upg_adr_i[13:0], passed through.
- rom_words_o  out  15  ROM words written in current/last upload.
- dmem_words_o  out  15  dmem words written in current/last upload.
- busy_o  out  1  high in ARM or LOAD.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, async):
  - state=BOOT; upg_rst_o=1; cpu_rst_o=1.
  - Counters, err_o, debounce counter and release counter are all cleared to 0.
  - Reset asserted mid-upload aborts the upload immediately; no further wen_o pulses.
- States:
  - BOOT:
    - Release counter counts up.
    - When it reaches RELEASE_CYCLES-1, go to RUN; cpu_rst_o falls on that edge.
    - cpu_rst_o is high for exactly RELEASE_CYCLES cycles after rst deasserts.
  - RUN:
    - cpu_rst_o=0, upg_rst_o=1.
    - Debounce counter increments while synced start_pg=1 and clears when it is 0.
    - When the counter reaches DEBOUNCE_CYCLES-1 with the button still high, go to ARM.
    - On entry to ARM: cpu_rst_o=1, upg_rst_o=0, both word counters clear, err_o clears.
  - ARM:
    - Waits for the first upg_wen_i, then goes to LOAD.
    - If upg_done_i arrives with no writes, go to DRAIN.
    - ARM is not subject to timeout (the PC tool may be slow to start).
  - LOAD:
    - Idle counter clears on every upg_wen_i.
    - upg_done_i=1 → DRAIN.
    - Idle counter reaching TIMEOUT_CYCLES-1 → DRAIN with err_o set to 1.
  - DRAIN:
    - upg_rst_o=1 on entry; cpu_rst_o stays 1.
    - Release counter runs for RELEASE_CYCLES, then go to RUN.
- Write steering (combinational, valid only in ARM/LOAD; forced 0 in all other states):
  - rom_wen_o = upg_wen_i & ~upg_adr_i[14]
  - dmem_wen_o = upg_wen_i & upg_adr_i[14]
  - Exactly one or neither enable is high in any cycle.
- Counters:
  - Each counter increments on the clock edge where its wen_o is high.
  - Counters saturate at 15'h7FFF.
  - Values hold after the upload until the next ARM entry.
- Simultaneous events:
  - upg_wen_i and upg_done_i in the same cycle: the write is steered and counted, then the transition to DRAIN happens.
  - The ARM→LOAD write is itself steered and counted.
- start_pg ignored outside RUN. A button still held after DRAIN does not re-arm until released for at least 1 synced cycle: a rearm latch clears only on synced start_pg=0.
- busy_o = (state==ARM || state==LOAD), registered alongside state.

Test Plan:
- Reset and boot: rst low 3 cycles, then high → cpu_rst_o=1 for exactly 8 cycles then 0; upg_rst_o=1; all counters 0.
- Short glitch: start_pg high 999 cycles then low → stays in RUN; cpu_rst_o=0.
- Valid press of 1000 cycles → ARM; cpu_rst_o=1, upg_rst_o=0. Then 3 writes at 0x0000–0x0002 and 2 writes at 0x4000–0x4001, then done → rom_wen_o 3 pulses, dmem_wen_o 2 pulses, rom_words_o=3, dmem_words_o=2. After 8 cycles in DRAIN → RUN, cpu_rst_o=0.
- wen with done same cycle at address 0x4005 → dmem_wen_o pulses once, dmem_words_o incremented, next state DRAIN.
- Timeout (TIMEOUT_CYCLES=50 for sim): one write then silence → after 50 idle cycles err_o=1, state DRAIN → RUN; a later press clears err_o.
- Async reset asserted mid-LOAD between edges → outputs immediately at reset values, wen outputs 0; button held through DRAIN does not re-arm until released.
